// File: rtl/apb_slave_mem_array_if.sv
// APB bus bundle shared by the master agent and the memory-array completer.
// The interface parameters must match the ones given to apb_slave_mem_array.
interface apb_slave_mem_array_if #(
    parameter int NO_OF_SLAVES  = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [NO_OF_SLAVES-1:0]   pselx;
    logic                      penable;
    logic                      pwrite;
    logic [ADDRESS_WIDTH-1:0]  paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic [3:0]                wait_cfg;
    logic                      pready;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pslverr;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, wait_cfg,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, wait_cfg,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_slave_mem_array.sv
// APB completer bank: NO_OF_SLAVES word memories behind one APB port, with byte
// strobes, programmable wait states, secure filtering and pslverr on illegal access.
module apb_slave_mem_array #(
    parameter int                      NO_OF_SLAVES    = 4,
    parameter int                      ADDRESS_WIDTH   = 32,
    parameter int                      DATA_WIDTH      = 32,
    parameter int                      SLAVE_MEM_WORDS = 16,
    parameter logic [NO_OF_SLAVES-1:0] SECURE_MASK     = '0
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    apb_slave_mem_array_if.slave  apb
);
    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int BYTE_OFF_W = $clog2(STRB_W);
    localparam int WORD_W     = (SLAVE_MEM_WORDS > 1) ? $clog2(SLAVE_MEM_WORDS) : 1;
    localparam int SEL_W      = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT = ADDRESS_WIDTH'(SLAVE_MEM_WORDS * STRB_W);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK   = ADDRESS_WIDTH'(STRB_W - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic                    err_q, err_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    pready_q, pready_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   mem_q [NO_OF_SLAVES][SLAVE_MEM_WORDS];
    logic [DATA_WIDTH-1:0]   mem_d [NO_OF_SLAVES][SLAVE_MEM_WORDS];

    logic                    setup;
    logic [SEL_W-1:0]        sel_now;
    logic [WORD_W-1:0]       word_now;
    logic                    err_now;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    go_done;
    logic                    unused_prot;

    assign unused_prot = ^{apb.pprot[2], apb.pprot[0]};
    assign setup       = (|apb.pselx) && !apb.penable;

    // Setup-phase decode; a multi-hot select is an error, so the lowest set bit is enough for indexing.
    always_comb begin
        sel_now = '0;
        for (int i = NO_OF_SLAVES - 1; i >= 0; i--) begin
            if (apb.pselx[i]) sel_now = SEL_W'(i);
        end
        word_now = WORD_W'(apb.paddr >> BYTE_OFF_W);
        err_now  = ((apb.pselx & (apb.pselx - NO_OF_SLAVES'(1))) != '0)
                || ((apb.paddr & OFF_MASK) != '0)
                || (apb.paddr >= ADDR_LIMIT)
                || (((apb.pselx & SECURE_MASK) != '0) && apb.pprot[1]);
    end

    assign rd_word = (state_q == IDLE) ? mem_q[sel_now][word_now] : mem_q[sel_q][word_q];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        word_d    = word_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        mem_d     = mem_q;
        go_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (setup) begin
                    sel_d   = sel_now;
                    word_d  = word_now;
                    write_d = apb.pwrite;
                    wdata_d = apb.pwdata;
                    strb_d  = apb.pstrb;
                    err_d   = err_now;
                    cnt_d   = apb.wait_cfg;
                    if (apb.wait_cfg == 4'd0) begin
                        state_d = DONE;
                        go_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!(|apb.pselx)) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    go_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                // Writes land at the end of the completion cycle, so a following read sees them.
                if ((|apb.pselx) && write_q && !err_q) begin
                    for (int j = 0; j < STRB_W; j++) begin
                        if (strb_q[j]) mem_d[sel_q][word_q][8*j +: 8] = wdata_q[8*j +: 8];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_done) begin
            pready_d  = 1'b1;
            pslverr_d = err_d;
            prdata_d  = (!err_d && !write_d) ? rd_word : '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            word_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            word_q    <= word_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            mem_q     <= mem_d;
        end
    end

    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_slave_mem_array.sv
// Self-checking bench for apb_slave_mem_array: directed cases plus random
// back-to-back traffic compared cycle by cycle against a behavioural memory model.
module tb_apb_slave_mem_array;
    localparam logic [3:0] SEC_MASK = 4'b0001;

    logic pclk = 1'b0;
    logic preset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   check_en = 1'b0;

    logic        exp_pready  = 1'b0;
    logic [31:0] exp_prdata  = '0;
    logic        exp_pslverr = 1'b0;

    logic [31:0] mm [4][16];

    apb_slave_mem_array_if #(.NO_OF_SLAVES(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_slave_mem_array #(
        .NO_OF_SLAVES(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
        .SLAVE_MEM_WORDS(16), .SECURE_MASK(SEC_MASK)
    ) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .apb      (bus)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle after reset the outputs must match what the model says for that cycle.
    always @(negedge pclk) begin
        if (check_en) begin
            checkOutput("pready",  32'(bus.pready),  32'(exp_pready));
            checkOutput("prdata",  bus.prdata,       exp_prdata);
            checkOutput("pslverr", 32'(bus.pslverr), 32'(exp_pslverr));
        end
    end

    function automatic bit model_err(input logic [3:0] sel, input logic [31:0] addr, input logic [2:0] prot);
        return ($countones(sel) > 1) || (addr % 4 != 0) || (addr >= 32'd64)
            || (((sel & SEC_MASK) != 4'd0) && prot[1]);
    endfunction

    function automatic int sel_index(input logic [3:0] sel);
        for (int i = 0; i < 4; i++) if (sel[i]) return i;
        return 0;
    endfunction

    task automatic clearModel();
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 16; w++) mm[s][w] = '0;
    endtask

    task automatic setExp(input logic rdy, input logic [31:0] rd, input logic er);
        exp_pready  = rdy;
        exp_prdata  = rd;
        exp_pslverr = er;
    endtask

    // One APB transfer; stop_at>0 drops pselx (or asserts reset) in that access cycle.
    task automatic applyStimulus(
        input  logic [3:0]  sel,  input logic [31:0] addr, input logic wr,
        input  logic [31:0] wd,   input logic [3:0]  st,   input logic [2:0] pr,
        input  int          wc,   input int stop_at,       input bit stop_rst,
        output logic [31:0] rd,   output logic er,         output int lat
    );
        bit e;
        int si;
        int wi;
        e  = model_err(sel, addr, pr);
        si = sel_index(sel);
        wi = int'((addr / 4) % 16);
        rd = '0; er = 1'b0; lat = 0;

        @(posedge pclk); #1;
        bus.pselx = sel; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr;
        bus.pwdata = wd; bus.pstrb = st; bus.pprot = pr; bus.wait_cfg = 4'(wc);
        setExp(1'b0, '0, 1'b0);

        for (int n = 1; n <= wc + 1; n++) begin
            @(posedge pclk); #1;
            bus.penable  = 1'b1;
            bus.wait_cfg = 4'($urandom);
            if (n == stop_at) begin
                if (stop_rst) preset_n = 1'b0;
                else begin
                    bus.pselx = '0; bus.penable = 1'b0;
                end
                setExp(1'b0, '0, 1'b0);
                @(negedge pclk);
                if (stop_rst) begin
                    @(posedge pclk); #1;
                    preset_n = 1'b1; bus.pselx = '0; bus.penable = 1'b0;
                    clearModel();
                    setExp(1'b0, '0, 1'b0);
                end
                return;
            end
            if (n == wc + 1) setExp(1'b1, (!e && !wr) ? mm[si][wi] : 32'd0, e);
            else             setExp(1'b0, '0, 1'b0);
            @(negedge pclk);
            if (bus.pready === 1'b1 && lat == 0) begin
                lat = n; rd = bus.prdata; er = bus.pslverr;
            end
        end

        if (wr && !e)
            for (int j = 0; j < 4; j++)
                if (st[j]) mm[si][wi][8*j +: 8] = wd[8*j +: 8];
    endtask

    // Idle cycles; a stray penable with a select but no setup must be ignored.
    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge pclk); #1;
            if ($urandom % 4 == 0) begin
                bus.pselx = 4'($urandom % 15 + 1); bus.penable = 1'b1;
            end else begin
                bus.pselx = '0; bus.penable = 1'($urandom);
            end
            setExp(1'b0, '0, 1'b0);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        preset_n = 1'b0;
        bus.pselx = '0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0;
        bus.pwdata = '0; bus.pstrb = '0; bus.pprot = '0; bus.wait_cfg = '0;
        clearModel();
        repeat (2) @(posedge pclk);
        #1;
        check_en = 1'b1;
        @(negedge pclk);
        checkOutput("reset_pready", 32'(bus.pready), 32'd0);
        checkOutput("reset_prdata", bus.prdata, 32'd0);
        @(posedge pclk); #1;
        preset_n = 1'b1;
        $display("[TB] reset released");

        // Basic write/read with no wait states.
        applyStimulus(4'b0010, 32'hC, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0, rd, er, lat);
        applyStimulus(4'b0010, 32'hC, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, 0, rd, er, lat);
        checkOutput("basic_rdata", rd, 32'hDEADBEEF);
        checkOutput("basic_lat", 32'(lat), 32'd1);
        checkOutput("basic_err", 32'(er), 32'd0);

        // Byte strobes: lanes 0 and 2 take the new bytes.
        applyStimulus(4'b0100, 32'h8, 1'b1, 32'h11223344, 4'hF, 3'b000, 0, 0, 0, rd, er, lat);
        applyStimulus(4'b0100, 32'h8, 1'b1, 32'hAABBCCDD, 4'b0101, 3'b000, 1, 0, 0, rd, er, lat);
        applyStimulus(4'b0100, 32'h8, 1'b0, 32'h0, 4'hF, 3'b000, 0, 0, 0, rd, er, lat);
        checkOutput("strb_rdata", rd, 32'h11BB33DD);

        // Wait states.
        applyStimulus(4'b0010, 32'hC, 1'b0, 32'h0, 4'h0, 3'b000, 3, 0, 0, rd, er, lat);
        checkOutput("wait3_lat", 32'(lat), 32'd4);
        checkOutput("wait3_rdata", rd, 32'hDEADBEEF);
        applyStimulus(4'b0010, 32'hC, 1'b0, 32'h0, 4'h0, 3'b000, 15, 0, 0, rd, er, lat);
        checkOutput("wait15_lat", 32'(lat), 32'd16);

        // Error cases.
        applyStimulus(4'b0001, 32'h4, 1'b1, 32'h12345678, 4'hF, 3'b000, 0, 0, 0, rd, er, lat);
        applyStimulus(4'b0001, 32'h41, 1'b1, 32'h1, 4'hF, 3'b000, 0, 0, 0, rd, er, lat);
        checkOutput("misaligned_err", 32'(er), 32'd1);
        applyStimulus(4'b0001, 32'h40, 1'b0, 32'h0, 4'hF, 3'b000, 2, 0, 0, rd, er, lat);
        checkOutput("range_err", 32'(er), 32'd1);
        checkOutput("range_rdata", rd, 32'd0);
        applyStimulus(4'b0110, 32'h8, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b000, 0, 0, 0, rd, er, lat);
        checkOutput("multisel_err", 32'(er), 32'd1);
        applyStimulus(4'b0001, 32'h4, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b010, 0, 0, 0, rd, er, lat);
        checkOutput("secure_wr_err", 32'(er), 32'd1);
        applyStimulus(4'b0001, 32'h4, 1'b0, 32'h0, 4'hF, 3'b010, 0, 0, 0, rd, er, lat);
        checkOutput("secure_rd_rdata", rd, 32'd0);
        applyStimulus(4'b0001, 32'h4, 1'b0, 32'h0, 4'hF, 3'b000, 0, 0, 0, rd, er, lat);
        checkOutput("secure_keep", rd, 32'h12345678);
        applyStimulus(4'b0100, 32'h8, 1'b0, 32'h0, 4'hF, 3'b000, 0, 0, 0, rd, er, lat);
        checkOutput("multisel_keep", rd, 32'h11BB33DD);

        // Abort during wait states, then reset in the middle of a write.
        applyStimulus(4'b0010, 32'hC, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000, 4, 2, 0, rd, er, lat);
        applyStimulus(4'b0010, 32'hC, 1'b0, 32'h0, 4'hF, 3'b000, 0, 0, 0, rd, er, lat);
        checkOutput("abort_keep", rd, 32'hDEADBEEF);
        applyStimulus(4'b1000, 32'h14, 1'b1, 32'h55AA55AA, 4'hF, 3'b000, 5, 3, 1, rd, er, lat);
        applyStimulus(4'b0010, 32'hC, 1'b0, 32'h0, 4'hF, 3'b000, 0, 0, 0, rd, er, lat);
        checkOutput("reset_clears", rd, 32'd0);
        applyStimulus(4'b1000, 32'h14, 1'b0, 32'h0, 4'hF, 3'b000, 1, 0, 0, rd, er, lat);
        checkOutput("reset_lost_wr", rd, 32'd0);

        // Random back-to-back traffic across all slaves.
        for (int t = 0; t < 300; t++) begin
            logic [3:0]  sel;
            logic [31:0] addr;
            int          wc;
            int          stop_at;
            bit          stop_rst;
            sel = ($urandom % 16 == 0) ? 4'($urandom % 15 + 1) : 4'(1 << ($urandom % 4));
            case ($urandom % 8)
                0:       addr = $urandom % 256;
                1:       addr = $urandom;
                default: addr = ($urandom % 16) * 4;
            endcase
            wc = ($urandom % 8 == 0) ? int'($urandom % 16) : int'($urandom % 4);
            stop_at  = (wc > 0 && $urandom % 16 == 0) ? int'($urandom % wc) + 1 : 0;
            stop_rst = (stop_at > 0) && ($urandom % 8 == 0);
            applyStimulus(sel, addr, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                          wc, stop_at, stop_rst, rd, er, lat);
            if ($urandom % 3 == 0) idleCycles(int'($urandom % 3) + 1);
        end

        idleCycles(2);
        @(negedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
